// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
package pipe_stall_ctrl_pkg;

   typedef logic [4:0] reg_idx_t;
   typedef logic [1:0] tcyc_t;

   // Tuse value meaning "operand not read".
   localparam tcyc_t TUSE_NONE = 2'd3;

   localparam int unsigned DEF_MULT_LAT = 5;
   localparam int unsigned DEF_DIV_LAT  = 10;

   typedef enum logic [1:0] {
      MdIdle    = 2'd0,
      MdBusyMul = 2'd1,
      MdBusyDiv = 2'd2
   } md_state_e;

   // Down-counter width: holds the larger latency minus one, never below 4 bits.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      int unsigned w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 4) ? 4 : w;
   endfunction

   // Tuse/Tnew hazard for one source operand against the E and M producers.
   function automatic logic src_hazard(input reg_idx_t src, input tcyc_t tuse,
                                       input reg_idx_t e_wa, input tcyc_t e_tnew,
                                       input reg_idx_t m_wa, input tcyc_t m_tnew);
      return (src != '0) && (tuse != TUSE_NONE) &&
             (((src == e_wa) && (e_tnew > tuse)) || ((src == m_wa) && (m_tnew > tuse)));
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Decode-side hazard bus between the pipeline and the stall controller.
interface pipe_stall_ctrl_if;
   import pipe_stall_ctrl_pkg::*;

   reg_idx_t    d_rs;
   reg_idx_t    d_rt;
   tcyc_t       d_tuse_rs;
   tcyc_t       d_tuse_rt;
   logic        d_is_md;
   reg_idx_t    e_wa;
   reg_idx_t    m_wa;
   tcyc_t       e_tnew;
   tcyc_t       m_tnew;
   logic        e_md_start;
   logic        e_md_div;
   logic        stall;
   logic        flush_e;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt;

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
      output e_wa, m_wa, e_tnew, m_tnew, e_md_start, e_md_div,
      input  stall, flush_e, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
      input  e_wa, m_wa, e_tnew, m_tnew, e_md_start, e_md_div,
      output stall, flush_e, md_busy, md_done, stall_cnt
   );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_seq.sv
// MDU busy-window sequencer: tracks the multi-cycle mult/div latency.
module md_busy_seq
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   input  logic md_div,
   output logic md_busy,
   output logic md_done
);

   localparam int unsigned CntW = cnt_width(MULT_LAT, DIV_LAT);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MdIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and busy/done decode; starts while busy are ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_busy = 1'b0;
      md_done = 1'b0;
      unique case (state_q)
         MdIdle: begin
            if (md_start) begin
               if (md_div) begin
                  state_d = MdBusyDiv;
                  cnt_d   = CntW'(DIV_LAT - 1);
               end else begin
                  state_d = MdBusyMul;
                  cnt_d   = CntW'(MULT_LAT - 1);
               end
            end
         end
         MdBusyMul, MdBusyDiv: begin
            md_busy = 1'b1;
            if (cnt_q == '0) begin
               md_done = 1'b1;
               state_d = MdIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d = MdIdle;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller: data-hazard compare, MDU stall and stall counter.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
   input logic              clk,
   input logic              rst,
   pipe_stall_ctrl_if.slave bus
);

   logic        haz_rs;
   logic        haz_rt;
   logic        haz_md;
   logic        stall;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt_q;

   md_busy_seq #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_busy_seq (
      .clk     (clk),
      .rst     (rst),
      .md_start(bus.e_md_start),
      .md_div  (bus.e_md_div),
      .md_busy (md_busy),
      .md_done (md_done)
   );

   // Combinational hazard detection; the start term covers the cycle before the FSM leaves idle.
   always_comb begin
      haz_rs = src_hazard(bus.d_rs, bus.d_tuse_rs, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew);
      haz_rt = src_hazard(bus.d_rt, bus.d_tuse_rt, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew);
      haz_md = bus.d_is_md && (md_busy || bus.e_md_start);
      stall  = haz_rs | haz_rt | haz_md;
   end

   // Free-running count of stalled edges, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall     = stall;
   assign bus.flush_e   = stall;
   assign bus.md_busy   = md_busy;
   assign bus.md_done   = md_done;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl against a cycle-count reference model.
module tb_pipe_stall_ctrl;
   import pipe_stall_ctrl_pkg::*;

   localparam int unsigned MLAT = 5;
   localparam int unsigned DLAT = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if bus ();

   pipe_stall_ctrl #(
      .MULT_LAT(MLAT),
      .DIV_LAT (DLAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   int          busy_left = 0;   // remaining busy cycles, including the current one
   logic [31:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_haz(input int src, input int tuse, input int ewa, input int etn,
                                    input int mwa, input int mtn);
      if (src == 0) return 1'b0;
      return ((src == ewa) && (etn > tuse)) || ((src == mwa) && (mtn > tuse));
   endfunction

   function automatic logic ref_stall();
      return ref_haz(int'(bus.d_rs), int'(bus.d_tuse_rs), int'(bus.e_wa), int'(bus.e_tnew),
                     int'(bus.m_wa), int'(bus.m_tnew)) ||
             ref_haz(int'(bus.d_rt), int'(bus.d_tuse_rt), int'(bus.e_wa), int'(bus.e_tnew),
                     int'(bus.m_wa), int'(bus.m_tnew)) ||
             (bus.d_is_md && ((busy_left > 0) || bus.e_md_start));
   endfunction

   task automatic idle_inputs();
      bus.d_rs       = '0;
      bus.d_rt       = '0;
      bus.d_tuse_rs  = TUSE_NONE;
      bus.d_tuse_rt  = TUSE_NONE;
      bus.d_is_md    = 1'b0;
      bus.e_wa       = '0;
      bus.m_wa       = '0;
      bus.e_tnew     = '0;
      bus.m_tnew     = '0;
      bus.e_md_start = 1'b0;
      bus.e_md_div   = 1'b0;
   endtask

   // Check all outputs against the model, take one clock edge, advance the model.
   task automatic tick(input string tag);
      logic s;
      #1;
      s = ref_stall();
      chk({tag, "/stall"}, {31'd0, bus.stall}, {31'd0, s});
      chk({tag, "/flush_e"}, {31'd0, bus.flush_e}, {31'd0, s});
      chk({tag, "/md_busy"}, {31'd0, bus.md_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
      chk({tag, "/md_done"}, {31'd0, bus.md_done}, (busy_left == 1) ? 32'd1 : 32'd0);
      chk({tag, "/stall_cnt"}, bus.stall_cnt, exp_cnt);
      @(posedge clk);
      if (rst) begin
         busy_left = 0;
         exp_cnt   = '0;
      end else begin
         if (s) exp_cnt = exp_cnt + 32'd1;
         if (busy_left > 0) busy_left = busy_left - 1;
         else if (bus.e_md_start) busy_left = bus.e_md_div ? DLAT : MLAT;
      end
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset/md_busy", {31'd0, bus.md_busy}, 32'd0);
      chk("reset/md_done", {31'd0, bus.md_done}, 32'd0);
      chk("reset/stall_cnt", bus.stall_cnt, 32'd0);
      chk("reset/stall", {31'd0, bus.stall}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // rs hazard against E, released when tnew drops.
      bus.d_rs = 5'd5; bus.d_tuse_rs = 2'd0; bus.e_wa = 5'd5; bus.e_tnew = 2'd1;
      #1;
      chk("rs_e/stall", {31'd0, bus.stall}, 32'd1);
      chk("rs_e/flush_e", {31'd0, bus.flush_e}, 32'd1);
      tick("rs_e");
      bus.e_tnew = 2'd0;
      #1;
      chk("rs_e_clear/stall", {31'd0, bus.stall}, 32'd0);
      tick("rs_e_clear");

      // $0 source and unused operand never stall; used rt against M does.
      idle_inputs();
      bus.d_rs = 5'd0; bus.d_tuse_rs = 2'd0; bus.e_wa = 5'd0; bus.e_tnew = 2'd2;
      #1;
      chk("zero_reg/stall", {31'd0, bus.stall}, 32'd0);
      tick("zero_reg");
      bus.d_rt = 5'd7; bus.m_wa = 5'd7; bus.m_tnew = 2'd2; bus.d_tuse_rt = TUSE_NONE;
      #1;
      chk("tuse_none/stall", {31'd0, bus.stall}, 32'd0);
      tick("tuse_none");
      bus.d_tuse_rt = 2'd1;
      #1;
      chk("rt_m/stall", {31'd0, bus.stall}, 32'd1);
      tick("rt_m");

      // Multiply window from a clean count.
      idle_inputs();
      rst = 1'b1;
      tick("rst_pulse");
      rst = 1'b0;
      bus.d_is_md = 1'b1; bus.e_md_start = 1'b1; bus.e_md_div = 1'b0;
      #1;
      chk("mul_T/stall", {31'd0, bus.stall}, 32'd1);
      tick("mul_T");
      bus.e_md_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk("mul_win/stall", {31'd0, bus.stall}, 32'd1);
         chk("mul_win/md_done", {31'd0, bus.md_done}, (i == 5) ? 32'd1 : 32'd0);
         tick("mul_win");
      end
      #1;
      chk("mul_end/stall", {31'd0, bus.stall}, 32'd0);
      chk("mul_end/stall_cnt", bus.stall_cnt, 32'd6);
      tick("mul_end");

      // Divide window; spurious start at T+3 must not extend it.
      idle_inputs();
      bus.e_md_start = 1'b1; bus.e_md_div = 1'b1;
      tick("div_T");
      for (int i = 1; i <= 10; i++) begin
         bus.e_md_start = (i == 3);
         bus.e_md_div   = 1'b1;
         #1;
         chk("div_win/md_busy", {31'd0, bus.md_busy}, 32'd1);
         tick("div_win");
      end
      // Back-to-back: new multiply immediately after the window.
      bus.e_md_start = 1'b1; bus.e_md_div = 1'b0;
      #1;
      chk("div_end/md_busy", {31'd0, bus.md_busy}, 32'd0);
      tick("b2b_T");
      bus.e_md_start = 1'b0;
      #1;
      chk("b2b/md_busy", {31'd0, bus.md_busy}, 32'd1);
      repeat (6) tick("b2b");

      // Reset in the middle of a divide with MD stalls accumulating.
      bus.d_is_md = 1'b1; bus.e_md_start = 1'b1; bus.e_md_div = 1'b1;
      tick("rstmid_T");
      bus.e_md_start = 1'b0;
      repeat (3) tick("rstmid_busy");
      rst = 1'b1;
      tick("rstmid_rst");
      rst = 1'b0;
      #1;
      chk("rstmid/md_busy", {31'd0, bus.md_busy}, 32'd0);
      chk("rstmid/stall_cnt", bus.stall_cnt, 32'd0);
      chk("rstmid/stall", {31'd0, bus.stall}, 32'd0);
      tick("rstmid_after");

      // Counter wrap: preload near the top, then two stalled edges.
      idle_inputs();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      exp_cnt = 32'hFFFF_FFFE;
      bus.d_rs = 5'd9; bus.d_tuse_rs = 2'd0; bus.m_wa = 5'd9; bus.m_tnew = 2'd1;
      repeat (2) tick("wrap");
      idle_inputs();
      #1;
      chk("wrap/stall_cnt", bus.stall_cnt, 32'd0);
      tick("wrap_end");

      // Randomized traffic over a small register space to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         bus.d_rs       = 5'($urandom_range(0, 3));
         bus.d_rt       = 5'($urandom_range(0, 3));
         bus.d_tuse_rs  = 2'($urandom_range(0, 3));
         bus.d_tuse_rt  = 2'($urandom_range(0, 3));
         bus.d_is_md    = 1'($urandom_range(0, 1));
         bus.e_wa       = 5'($urandom_range(0, 3));
         bus.m_wa       = 5'($urandom_range(0, 3));
         bus.e_tnew     = 2'($urandom_range(0, 2));
         bus.m_tnew     = 2'($urandom_range(0, 2));
         bus.e_md_start = ($urandom_range(0, 5) == 0);
         bus.e_md_div   = 1'($urandom_range(0, 1));
         rst            = ($urandom_range(0, 79) == 0);
         tick("rand");
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
